// File: rtl/renas_ahb_master_port_pkg.sv
// Shared types for the renas AHB master port: FSM states, bus structs and data width.
package renas_ahb_master_port_pkg;

  localparam int DATA_LENGTH = 32;

  typedef enum logic [1:0] {IDLE, REQ, GAP} ahbm_state_e;

  typedef struct packed {
    logic [31:0]            haddr;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [2:0]             hburst;
    logic [3:0]             hprot;
    logic [1:0]             htrans;
    logic                   hmastlock;
    logic [DATA_LENGTH-1:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic                   hreadyout;
    logic                   hresp;
    logic [DATA_LENGTH-1:0] hrdata;
  } slv_send_type;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/renas_sync_fifo.sv
// Small synchronous FIFO with count-based full/empty; DEPTH must be a power of two.
module renas_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/renas_ahb_master_port.sv
// AHB initiator: queues CPU word requests, runs one hsel transfer at a time and returns a response pulse.
module renas_ahb_master_port
  import renas_ahb_master_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk_l2,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   hsel,
  output mas_send_type           m_out,
  input  slv_send_type           s_in,
  output logic                   busy
);
  localparam int FW = 1 + 32 + DATA_LENGTH;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  ahbm_state_e            r_state;
  logic                   r_hsel;
  logic                   r_rdy_en;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic [DATA_LENGTH-1:0] r_rsp_rdata;
  mas_send_type           r_m_out;
  logic [TW-1:0]          r_tcnt;
  logic [GW-1:0]          r_gcnt;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [FW-1:0]          w_fifo_rdata;
  logic                   w_head_write;
  logic [31:0]            w_head_addr;
  logic [DATA_LENGTH-1:0] w_head_wdata;

  // req_ready stays low through reset and rises the cycle after release.
  assign req_ready = r_rdy_en & ~w_full;
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_state == IDLE) & ~w_empty;

  assign w_head_write = w_fifo_rdata[FW-1];
  assign w_head_addr  = w_fifo_rdata[FW-2 -: 32];
  assign w_head_wdata = w_fifo_rdata[DATA_LENGTH-1:0];

  assign hsel      = r_hsel;
  assign m_out     = r_m_out;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE) | ~w_empty;

  renas_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_l2),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({req_write, req_addr, req_wdata}),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_l2) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hsel      <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_m_out     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_tcnt      <= '0;
      r_gcnt      <= '0;
    end else begin
      r_rdy_en    <= 1'b1;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state        <= REQ;
            r_hsel         <= 1'b1;
            r_m_out        <= '0;
            r_m_out.haddr  <= word_align(w_head_addr);
            r_m_out.hwrite <= w_head_write;
            r_m_out.hwdata <= w_head_wdata;
            r_tcnt         <= '0;
          end
        end
        REQ: begin
          // A ready arriving on the last timeout cycle still completes normally.
          if (s_in.hreadyout) begin
            r_state     <= GAP;
            r_hsel      <= 1'b0;
            r_m_out     <= '0;
            r_gcnt      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= s_in.hresp;
            r_rsp_rdata <= r_m_out.hwrite ? '0 : s_in.hrdata;
          end else if (r_tcnt == T_LAST) begin
            r_state     <= GAP;
            r_hsel      <= 1'b0;
            r_m_out     <= '0;
            r_gcnt      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt >= G_LAST) r_state <= IDLE;
          else                  r_gcnt  <= r_gcnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renas_ahb_master_port.sv
// Directed-plus-random bench for renas_ahb_master_port with a delay-programmable memory slave.
module tb_renas_ahb_master_port;
  import renas_ahb_master_port_pkg::*;

  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          outcome;  // 0 ok, 1 slave error, 2 timeout
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        clean;    // other fields zero and m_out stable over REQ
  } bus_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         hsel;
  mas_send_type m_out;
  slv_send_type s_in = '0;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  int          rise_q[$];
  int          gap_q[$];
  logic [31:0] rmem[int];
  logic [31:0] smem[int];

  int           slv_mode = 1;   // 0 random delay 1..6, 1 fixed slv_dly
  int           slv_dly  = 2;
  logic         slv_err  = 1'b0;
  int           slv_skip = 0;
  int           scnt     = 0;
  int           sdly     = 0;
  logic         signore  = 1'b0;
  mas_send_type sfirst;
  logic         prev_rv  = 1'b0;
  logic         prev_hs  = 1'b0;
  int           low_run  = 0;

  renas_ahb_master_port #(
    .FIFO_DEPTH (2),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_l2    (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .hsel      (hsel),
    .m_out     (m_out),
    .s_in      (s_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory slave: one-cycle hreadyout pulse on the sdly-th cycle of hsel.
  always @(negedge clk) begin
    if (!hsel) begin
      scnt = 0;
      s_in.hreadyout = 1'b0;
    end else if (s_in.hreadyout) begin
      s_in.hreadyout = 1'b0;
    end else begin
      if (scnt == 0) begin
        sfirst  = m_out;
        sdly    = (slv_mode == 0) ? int'($urandom_range(1, 6)) : slv_dly;
        signore = (slv_skip > 0);
        if (slv_skip > 0) slv_skip--;
      end
      scnt++;
      if (!signore && scnt == sdly) begin
        bus_t b;
        s_in.hreadyout = 1'b1;
        s_in.hresp     = slv_err;
        if (slv_err) s_in.hrdata = $urandom;
        else s_in.hrdata = smem.exists(int'(m_out.haddr >> 2)) ? smem[int'(m_out.haddr >> 2)] : 32'h0;
        if (!slv_err && m_out.hwrite) smem[int'(m_out.haddr >> 2)] = m_out.hwdata;
        b.haddr  = m_out.haddr;
        b.hwrite = m_out.hwrite;
        b.hwdata = m_out.hwdata;
        b.clean  = (m_out === sfirst) &&
                   ({m_out.hsize, m_out.hburst, m_out.hprot, m_out.htrans, m_out.hmastlock} == '0);
        bus_q.push_back(b);
      end
    end
  end

  // Response and hsel monitor.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_t r;
      check("rsp_single_pulse", prev_rv, 0);
      r.rdata = rsp_rdata;
      r.err   = rsp_err;
      r.cyc   = cyc;
      rsp_q.push_back(r);
    end
    prev_rv = rsp_valid;
    if (hsel === 1'b1) begin
      if (!prev_hs) begin
        rise_q.push_back(cyc);
        gap_q.push_back(low_run);
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_hs = hsel;
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int outcome, output int acc);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge clk);
    if (!req_ready) check("send_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    e.w       = w;
    e.addr    = a & 32'hFFFF_FFFC;
    e.wdata   = d;
    e.outcome = outcome;
    if (outcome == 0 && w) rmem[int'(a >> 2)] = d;
    if (w || outcome != 0) e.rdata = 32'h0;
    else e.rdata = rmem.exists(int'(a >> 2)) ? rmem[int'(a >> 2)] : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_rsp(input string tag, output int rcyc);
    exp_t e;
    rsp_t r;
    bus_t b;
    rcyc = -1;
    for (int i = 0; i < 400 && rsp_q.size() == 0; i++) @(negedge clk);
    if (rsp_q.size() == 0 || exp_q.size() == 0) begin
      check({tag, "_rsp_seen"}, rsp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    r = rsp_q.pop_front();
    rcyc = r.cyc;
    check({tag, "_err"}, r.err, (e.outcome != 0));
    if (e.outcome != 1) check({tag, "_rdata"}, r.rdata, e.rdata);
    if (e.outcome != 2) begin
      if (bus_q.size() == 0) begin
        check({tag, "_bus_seen"}, bus_q.size(), 1);
        return;
      end
      b = bus_q.pop_front();
      check({tag, "_haddr"}, b.haddr, e.addr);
      check({tag, "_hwrite"}, b.hwrite, e.w);
      if (e.w) check({tag, "_hwdata"}, b.hwdata, e.wdata);
      check({tag, "_mout_clean"}, b.clean, 1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check("return_idle", busy, 0);
  endtask

  initial begin
    int acc;
    int acc4;
    int rc;
    int first_rsp;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hsel", hsel, 0);
    check("rst_m_out", m_out, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);

    // Store then load, back to back
    slv_mode = 1; slv_dly = 2; slv_err = 1'b0;
    gap_q.delete();
    send(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, acc);
    send(1'b0, 32'h0000_0043, 32'h0, 0, acc);
    check_rsp("st40", rc);
    check_rsp("ld40", rc);
    if (gap_q.size() >= 2)
      check("gap_hsel_low", (gap_q[1] >= GAP_CYCLES) && (gap_q[1] <= GAP_CYCLES + 1), 1);
    else
      check("gap_rises", gap_q.size(), 2);
    wait_idle();

    // Randomized traffic, random slave latency
    slv_mode = 0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), a, $urandom, 0, acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    for (int i = 0; i < 24; i++) check_rsp($sformatf("rnd%0d", i), rc);
    wait_idle();

    // FIFO full with a slow slave
    slv_mode = 1; slv_dly = 20;
    send(1'b1, 32'h200, 32'h1111_0001, 0, acc);
    send(1'b1, 32'h204, 32'h2222_0002, 0, acc);
    send(1'b0, 32'h200, 32'h0, 0, acc);
    check("full_ready_low", req_ready, 0);
    check("full_busy", busy, 1);
    send(1'b0, 32'h204, 32'h0, 0, acc4);
    check_rsp("full0", first_rsp);
    check("full_4th_after_rsp", (acc4 > first_rsp), 1);
    check_rsp("full1", rc);
    check_rsp("full2", rc);
    check_rsp("full3", rc);
    wait_idle();

    // Timeout, then the queued request completes
    slv_mode = 1; slv_dly = 3; slv_skip = 1;
    rise_q.delete();
    send(1'b0, 32'h44, 32'h0, 2, acc);
    send(1'b1, 32'h48, 32'hCAFE_F00D, 0, acc);
    check_rsp("tmo", rc);
    if (rise_q.size() > 0) check("tmo_latency", rc - rise_q[0], TIMEOUT);
    else check("tmo_rise_seen", rise_q.size(), 1);
    check_rsp("after_tmo", rc);
    wait_idle();

    // Slave error response
    slv_err = 1'b1; slv_dly = 2;
    send(1'b1, 32'h80, 32'h5555_AAAA, 1, acc);
    send(1'b0, 32'h40, 32'h0, 1, acc);
    check_rsp("err_st", rc);
    check_rsp("err_ld", rc);
    wait_idle();
    slv_err = 1'b0;

    // hreadyout on the final timeout cycle wins
    slv_dly = TIMEOUT;
    rise_q.delete();
    send(1'b0, 32'h40, 32'h0, 0, acc);
    check_rsp("tie", rc);
    if (rise_q.size() > 0) check("tie_latency", rc - rise_q[0], TIMEOUT);
    else check("tie_rise_seen", rise_q.size(), 1);
    wait_idle();

    // Reset in the middle of REQ
    slv_dly = 30;
    send(1'b0, 32'h40, 32'h0, 0, acc);
    for (int i = 0; i < 20 && !hsel; i++) @(negedge clk);
    check("mid_hsel_up", hsel, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hsel", hsel, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("mid_no_rsp", rsp_q.size(), 0);
    check("mid_hsel_stays_low", hsel, 0);
    check("mid_busy_after", busy, 0);
    check("mid_ready_after", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
